fp_mul_normalize: RTL and testbench
===================================

FP_MUL_NORMALIZE -- requirements
Module: fp_mul_normalize

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream product valid
- in_ready  output  1  block can accept a product this cycle
- prod  input  48  unsigned 24x24 mantissa product from the multiplier_adder array; value in [1,4)
- exp_sum  input  10  signed two's-complement biased exponent, ea+eb-127
- sign  input  1  result sign, sa^sb
- special  input  2  00 normal, 01 zero, 10 infinity, 11 NaN
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  32  IEEE-754 single-precision result
- flags  output  3  {overflow, underflow, inexact}, qualified by out_valid

Function
REQ-002 The block SHALL be a 2-stage pipeline: S1 normalizes, S2 rounds and packs.
REQ-003 A transfer SHALL occur on a rising edge where valid and ready are both high, on either port.
REQ-004 Each stage SHALL advance when it is empty, or when the stage after it advances or is empty.
- in_ready = !s1_valid | s1_advance
REQ-005 With out_ready held high, latency SHALL be 2 cycles from input transfer to out_valid, at a throughput of 1 result per cycle.
REQ-006 While out_valid=1 and out_ready=0, result, flags and out_valid SHALL hold stable.
REQ-007 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-008 S1 SHALL normalize as follows:
- if prod[47]=1: mant=prod[46:24], G=prod[23], St=|prod[22:0], e=exp_sum+1
- else: mant=prod[45:23], G=prod[22], St=|prod[21:0], e=exp_sum
REQ-009 S2 SHALL round to nearest even: increment mant when G & (St | mant[0]).
REQ-010 A mantissa carry-out from rounding SHALL set mant=0 and e=e+1.
REQ-011 inexact SHALL equal G|St for normal inputs.
REQ-012 If the final e>=255, the output SHALL be {sign,8'hFF,23'h0} with overflow=1 and inexact=1.
REQ-013 If the final e<=0, the output SHALL be {sign,31'h0} (flush-to-zero, no subnormals) with underflow=1 and inexact=1.
REQ-014 For special=00 with prod[47:46]=00, the output SHALL be {sign,31'h0} with underflow=1.
REQ-015 For special=01, the output SHALL be {sign,31'h0} with flags=000.
REQ-016 For special=10, the output SHALL be {sign,8'hFF,23'h0} with flags=000.
REQ-017 For special=11, the output SHALL be 32'h7FC00000 with flags=000, ignoring sign.
REQ-018 Internal exponent arithmetic SHALL be at least 11-bit signed so that e+1 never wraps.
REQ-019 prod and exp_sum SHALL be don't-care when special!=00.

Reset
REQ-020 While rst_n=0, out_valid=0, result=32'h0, flags=3'b000, in_ready=0, and both stages SHALL be empty.
REQ-021 Reset assertion SHALL take effect immediately without a clock edge, discarding any in-flight data.
REQ-022 in_ready SHALL be 1 on the first clock after rst_n deasserts.

Verification
REQ-023 prod=48'h600000000000, exp_sum=128, sign=0, special=00 -> result 32'h40400000 (3.0), flags 000, out_valid 2 cycles later.
REQ-024 prod=48'h900000000000, exp_sum=127 -> 32'h40100000 (2.25), flags 000.
REQ-025 exp_sum=127 with two rounding cases:
- prod=48'h400000400000 (tie, even lsb) -> 32'h3F800000, inexact=1
- prod=48'h400000C00000 (tie, odd lsb) -> 32'h3F800002, inexact=1
REQ-026 prod=48'h800000000000 with exp_sum=254, sign=1 -> 32'hFF800000, flags 101; exp_sum=-5 -> 32'h80000000, flags 011.
REQ-027 Hold out_ready=0, offer 4 back-to-back inputs -> exactly 2 accepted, in_ready=0, output stable; then raise out_ready -> remaining inputs accepted, all 4 results emerge in order with none lost.
REQ-028 Assert rst_n=0 mid-stream with both stages full -> out_valid=0 immediately; after release, only inputs offered after reset appear.

Source files
------------

// File: rtl/fp_mul_normalize.sv
// Floating-point multiply back end: normalizes a 24x24 mantissa product,
// rounds to nearest even and packs an IEEE-754 single-precision result.
//
// Two register stages, S1 (normalize) and S2 (round/pack; S2 drives the
// outputs directly).
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds its data stable while valid is high and ready
// is low. out_valid never depends combinationally on out_ready. in_ready is
// a combinational function of stage occupancy and out_ready.
module fp_mul_normalize (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] prod,
  input  logic [9:0]  exp_sum,
  input  logic        sign,
  input  logic [1:0]  special,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  localparam logic [1:0] SP_NORMAL = 2'b00;
  localparam logic [1:0] SP_ZERO   = 2'b01;
  localparam logic [1:0] SP_INF    = 2'b10;
  localparam logic [1:0] SP_NAN    = 2'b11;

  // Pipeline occupancy and advance conditions
  logic s1_valid;
  logic s1_advance;
  logic s2_advance;

  assign s2_advance = !out_valid | out_ready;
  assign s1_advance = !s1_valid | s2_advance;
  // Gated by rst_n so the block refuses input while held in reset.
  assign in_ready   = rst_n & (!s1_valid | s1_advance);

  // S1 normalize (combinational front)
  logic signed [10:0] exp_ext;
  logic signed [10:0] n_exp;
  logic [22:0]        n_mant;
  logic               n_g;
  logic               n_st;
  logic               n_low;

  assign exp_ext = {exp_sum[9], exp_sum};

  // Pick the mantissa window based on whether the product is in [2,4) or [1,2)
  always_comb begin
    n_exp  = exp_ext;
    n_mant = prod[45:23];
    n_g    = prod[22];
    n_st   = |prod[21:0];
    if (prod[47]) begin
      n_exp  = exp_ext + 11'sd1;
      n_mant = prod[46:24];
      n_g    = prod[23];
      n_st   = |prod[22:0];
    end
  end

  // A product below 1.0 means the operand was not normalized; flushed later.
  assign n_low = (prod[47:46] == 2'b00);

  // S1 registers
  logic               s1_sign;
  logic [1:0]         s1_special;
  logic               s1_low;
  logic [22:0]        s1_mant;
  logic               s1_g;
  logic               s1_st;
  logic signed [10:0] s1_exp;

  // S1 register: capture the normalized fields whenever the stage advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_special <= SP_NORMAL;
      s1_low     <= 1'b0;
      s1_mant    <= 23'd0;
      s1_g       <= 1'b0;
      s1_st      <= 1'b0;
      s1_exp     <= 11'sd0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= sign;
        s1_special <= special;
        s1_low     <= n_low;
        s1_mant    <= n_mant;
        s1_g       <= n_g;
        s1_st      <= n_st;
        s1_exp     <= n_exp;
      end
    end
  end

  // S2 round to nearest even and pack (combinational front)
  logic               round_inc;
  logic [23:0]        mant_sum;
  logic [22:0]        r_mant;
  logic signed [10:0] r_exp;
  logic               inexact;
  logic [31:0]        n_result;
  logic [2:0]         n_flags;

  assign round_inc = s1_g & (s1_st | s1_mant[0]);
  assign mant_sum  = {1'b0, s1_mant} + {23'd0, round_inc};
  // Carry out of the mantissa means it rolled over to 1.0 of the next binade.
  assign r_mant    = mant_sum[23] ? 23'd0 : mant_sum[22:0];
  assign r_exp     = s1_exp + $signed({10'd0, mant_sum[23]});
  assign inexact   = s1_g | s1_st;

  // Select the packed word and flags: specials first, then range checks
  always_comb begin
    n_result = {s1_sign, r_exp[7:0], r_mant};
    n_flags  = {2'b00, inexact};
    case (s1_special)
      SP_ZERO: begin
        n_result = {s1_sign, 31'h0};
        n_flags  = 3'b000;
      end
      SP_INF: begin
        n_result = {s1_sign, 8'hFF, 23'h0};
        n_flags  = 3'b000;
      end
      SP_NAN: begin
        n_result = 32'h7FC0_0000;
        n_flags  = 3'b000;
      end
      default: begin
        if (s1_low) begin
          n_result = {s1_sign, 31'h0};
          n_flags  = 3'b010;
        end else if (r_exp >= 11'sd255) begin
          n_result = {s1_sign, 8'hFF, 23'h0};
          n_flags  = 3'b101;
        end else if (r_exp <= 11'sd0) begin
          n_result = {s1_sign, 31'h0};
          n_flags  = 3'b011;
        end
      end
    endcase
  end

  // S2 register: drives the outputs; holds while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 32'h0;
      flags     <= 3'b000;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= n_result;
        flags  <= n_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Directed bench for fp_mul_normalize: an arithmetic reference model feeds
// an expected queue; a negedge monitor compares every output transfer.
module tb_fp_mul_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] prod = 48'd0;
  logic [9:0]  exp_sum = 10'd0;
  logic        sign = 1'b0;
  logic [1:0]  special = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0]  flags;

  fp_mul_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .exp_sum   (exp_sum),
    .sign      (sign),
    .special   (special),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // Clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  logic [34:0] exp_q[$];

  // Directed vector table: inputs plus hand-computed {flags,result}
  logic [47:0] vp  [32];
  logic [9:0]  ves [32];
  logic        vs  [32];
  logic [1:0]  vsp [32];
  logic [31:0] vres[32];
  logic [2:0]  vfl [32];
  int nv = 0;

  task automatic add_vec(input logic [47:0] p, input int es, input logic s,
                         input logic [1:0] sp, input logic [31:0] r, input logic [2:0] f);
    vp[nv] = p; ves[nv] = es[9:0]; vs[nv] = s; vsp[nv] = sp;
    vres[nv] = r; vfl[nv] = f;
    nv++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: treats prod as the integer prod * 2^-46 and rounds the
  // 24-bit significand with remainder arithmetic. Returns {flags, result}.
  function automatic logic [34:0] model(input logic [47:0] p, input int es,
                                        input logic s, input logic [1:0] sp);
    longint pl, m, rem, half;
    int sh, e;
    logic inex;
    logic [7:0] e8;
    logic [22:0] m23;
    if (sp == 2'b01) return {3'b000, s, 31'h0};
    if (sp == 2'b10) return {3'b000, s, 8'hFF, 23'h0};
    if (sp == 2'b11) return {3'b000, 32'h7FC0_0000};
    pl = {16'd0, p};
    if (pl < (longint'(1) << 46)) return {3'b010, s, 31'h0};
    sh = (pl >= (longint'(1) << 47)) ? 24 : 23;
    e = es + (sh - 23);
    m = pl >> sh;
    rem = pl - (m << sh);
    half = longint'(1) << (sh - 1);
    inex = (rem != 0);
    if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
    if (m == (longint'(1) << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b101, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b011, s, 31'h0};
    e8 = e[7:0];
    m23 = m[22:0];
    return {2'b00, inex, s, e8, m23};
  endfunction

  // Monitor / scoreboard: sample away from the rising edge
  logic        hold = 1'b0;
  logic [31:0] h_res;
  logic [2:0]  h_fl;
  logic [34:0] exp_item;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_result", result, h_res);
        check("hold_flags", flags, h_fl);
      end
      if (out_valid && out_ready) begin
        check("output_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_item = exp_q.pop_front();
          check("result", result, exp_item[31:0]);
          check("flags", flags, exp_item[34:32]);
        end
        out_cnt++;
      end
      hold  = out_valid && !out_ready;
      h_res = result;
      h_fl  = flags;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(prod, $signed(exp_sum), sign, special));
        acc_cnt++;
      end
    end
  end

  // Driver: present one input and hold it until accepted (bounded)
  task automatic send(input int i);
    int n;
    bit done;
    prod = vp[i]; exp_sum = ves[i]; sign = vs[i]; special = vsp[i];
    in_valid = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("send_accepted", done, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a0, o0;
    add_vec(48'h6000_0000_0000, 128, 0, 2'b00, 32'h4040_0000, 3'b000); // 0
    add_vec(48'h9000_0000_0000, 127, 0, 2'b00, 32'h4010_0000, 3'b000); // 1
    add_vec(48'h4000_0040_0000, 127, 0, 2'b00, 32'h3F80_0000, 3'b001); // 2
    add_vec(48'h4000_00C0_0000, 127, 0, 2'b00, 32'h3F80_0002, 3'b001); // 3
    add_vec(48'h8000_0000_0000, 254, 1, 2'b00, 32'hFF80_0000, 3'b101); // 4
    add_vec(48'h8000_0000_0000, -5,  1, 2'b00, 32'h8000_0000, 3'b011); // 5
    add_vec(48'h1234_5678_9ABC, 300, 1, 2'b01, 32'h8000_0000, 3'b000); // 6
    add_vec(48'hFFFF_FFFF_FFFF, -3,  0, 2'b10, 32'h7F80_0000, 3'b000); // 7
    add_vec(48'h0000_0000_0001, 5,   1, 2'b11, 32'h7FC0_0000, 3'b000); // 8
    add_vec(48'h0000_0000_0000, 127, 1, 2'b00, 32'h8000_0000, 3'b010); // 9
    add_vec(48'h7FFF_FFFF_FFFF, 127, 0, 2'b00, 32'h4000_0000, 3'b001); // 10
    add_vec(48'h4000_0000_0000, 0,   0, 2'b00, 32'h0000_0000, 3'b011); // 11
    add_vec(48'h4000_0000_0000, 1,   0, 2'b00, 32'h0080_0000, 3'b000); // 12
    add_vec(48'h4000_0000_0000, 254, 0, 2'b00, 32'h7F00_0000, 3'b000); // 13
    add_vec(48'h7FFF_FFFF_FFFF, 254, 0, 2'b00, 32'h7F80_0000, 3'b101); // 14
    add_vec(48'h4000_0000_0001, 127, 0, 2'b00, 32'h3F80_0000, 3'b001); // 15
    add_vec(48'h4000_0060_0000, 127, 0, 2'b00, 32'h3F80_0001, 3'b001); // 16
    add_vec(48'h7FFF_FFFF_FFFF, -1,  0, 2'b00, 32'h0000_0000, 3'b011); // 17
    add_vec(48'h7FFF_FFFF_FFFF, 0,   0, 2'b00, 32'h0080_0000, 3'b001); // 18
    add_vec(48'h8000_0000_0000, 511, 0, 2'b00, 32'h7F80_0000, 3'b101); // 19
    add_vec(48'hC000_0000_0000, -512, 0, 2'b00, 32'h0000_0000, 3'b011); // 20
    add_vec(48'hA000_0000_0000, 126, 0, 2'b00, 32'h3FA0_0000, 3'b000); // 21
    add_vec(48'h8000_0180_0000, 127, 0, 2'b00, 32'h4000_0002, 3'b001); // 22
    add_vec(48'h8000_0000_0000, -1,  1, 2'b00, 32'h8000_0000, 3'b011); // 23
    add_vec(48'h8000_0000_0000, 0,   0, 2'b00, 32'h0080_0000, 3'b000); // 24

    // Reset state while rst_n is held low
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    check("reset_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Pin the model to the hand-computed table
    for (int i = 0; i < nv; i++)
      check($sformatf("model_vec%0d", i),
            model(vp[i], $signed(ves[i]), vs[i], vsp[i]), {vfl[i], vres[i]});

    // Latency: accepted at edge k, out_valid visible after edge k+1
    send(0);
    @(negedge clk);
    check("latency_not_early", out_valid, 0);
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
    check("latency_result", result, 32'h4040_0000);
    check("latency_flags", flags, 3'b000);
    @(posedge clk);
    #1;

    // Full table back-to-back with out_ready high
    for (int i = 0; i < nv; i++) send(i);
    drain();

    // Full table again with a stalling downstream
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          @(posedge clk);
          #1;
          out_ready = (k % 3) != 1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = nv - 1; i >= 0; i--) send(i);
      end
    join
    drain();

    // Backpressure: four offered with out_ready low, only two fit
    out_ready = 1'b0;
    a0 = acc_cnt;
    o0 = out_cnt;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(i);
      end
      begin
        repeat (8) @(negedge clk);
        check("stall_accepted_two", acc_cnt - a0, 2);
        check("stall_in_ready_low", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_first_result", result, 32'h4010_0000);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_all_four_out", out_cnt - o0, 4);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send(5);
    send(6);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_result", result, 0);
    check("midreset_flags", flags, 0);
    check("midreset_in_ready", in_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_midreset", in_ready, 1);
    o0 = out_cnt;
    send(21);
    drain();
    repeat (3) @(negedge clk);
    check("midreset_only_new_output", out_cnt - o0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
